error_gain_scheduler: RTL

Sequential gain-scheduling controller for the four-input error combiner in the ADPLL loop. It watches the primary phase-error stream, runs a three-state acquisition/tracking/lock state machine with consecutive-sample counters, and drives the four combiner weights so the loop gain steps down as lock is approached. It sits between the phase detector outputs and the combiner's weight inputs; the combiner itself stays purely combinational.

---
 rtl/error_gain_scheduler.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/error_gain_scheduler.sv
// -----------------------------------------------------------------------------
// error_gain_scheduler
//
// Gain-scheduling controller for the ADPLL four-input error combiner. It
// watches the primary phase-error stream, runs an ACQUIRE / TRACK / LOCKED
// state machine driven by consecutive-sample counting, and produces
// registered combiner weights. The weights step down as lock is approached:
//   ACQUIRE = 4,2,1,1   TRACK = 2,2,1,1   LOCKED = 1,1,1,1
//
// Build option:
//   ERROR_GAIN_SCHED_STEPDOWN_EN  defined   -> an unlock in LOCKED falls back
//                                              to TRACK.
//                                 undefined -> an unlock in LOCKED falls back
//                                              to ACQUIRE.
//
// Ports:
//   clk_i            single clock, all state changes on the rising edge
//   reset_i          synchronous active-high reset (highest priority)
//   sample_valid_i   one-cycle strobe qualifying error_0_i
//   error_0_i        signed primary phase error
//   force_acquire_i  synchronous restart of acquisition (beats a sample)
//   weight_0_o..3_o  registered combiner weights, decoded from next state
//   state_o          0=ACQUIRE, 1=TRACK, 2=LOCKED
//   locked_o         high only while LOCKED
//   weights_update_o one-cycle pulse after every state change
// -----------------------------------------------------------------------------
module error_gain_scheduler #(
    parameter int ERROR_WIDTH   = 8,
    parameter int WEIGHT_WIDTH  = 3,
    parameter int LOCK_THRESH   = 4,
    parameter int UNLOCK_THRESH = 16,
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_COUNT  = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          sample_valid_i,
    input  logic signed [ERROR_WIDTH-1:0] error_0_i,
    input  logic                          force_acquire_i,
    output logic [WEIGHT_WIDTH-1:0]       weight_0_o,
    output logic [WEIGHT_WIDTH-1:0]       weight_1_o,
    output logic [WEIGHT_WIDTH-1:0]       weight_2_o,
    output logic [WEIGHT_WIDTH-1:0]       weight_3_o,
    output logic [1:0]                    state_o,
    output logic                          locked_o,
    output logic                          weights_update_o
);

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_TRACK   = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam int MAX_COUNT = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
    localparam int CNT_W     = $clog2(MAX_COUNT + 1);

    localparam logic [CNT_W-1:0] ACQ_TARGET    = CNT_W'(LOCK_COUNT / 2);
    localparam logic [CNT_W-1:0] TRACK_TARGET  = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] UNLOCK_TARGET = CNT_W'(UNLOCK_COUNT);

    localparam logic [ERROR_WIDTH:0] LOCK_LIMIT   = (ERROR_WIDTH + 1)'(LOCK_THRESH);
    localparam logic [ERROR_WIDTH:0] UNLOCK_LIMIT = (ERROR_WIDTH + 1)'(UNLOCK_THRESH);

`ifdef ERROR_GAIN_SCHED_STEPDOWN_EN
    localparam state_t UNLOCK_DEST = ST_TRACK;
`else
    localparam state_t UNLOCK_DEST = ST_ACQUIRE;
`endif

    // Weight table indexed by state and combiner input.
    function automatic logic [WEIGHT_WIDTH-1:0] weight_for(input state_t s, input int idx);
        logic [WEIGHT_WIDTH-1:0] w;
        w = WEIGHT_WIDTH'(1);
        case (idx)
            0: begin
                case (s)
                    ST_ACQUIRE: w = WEIGHT_WIDTH'(4);
                    ST_TRACK:   w = WEIGHT_WIDTH'(2);
                    default:    w = WEIGHT_WIDTH'(1);
                endcase
            end
            1: w = (s == ST_LOCKED) ? WEIGHT_WIDTH'(1) : WEIGHT_WIDTH'(2);
            default: w = WEIGHT_WIDTH'(1);
        endcase
        return w;
    endfunction

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CNT_W-1:0]  cnt_inc;
    logic              locked_reg;
    logic              update_reg;

    // Magnitude in one extra bit so the most negative code does not wrap.
    logic signed [ERROR_WIDTH:0] err_ext;
    logic [ERROR_WIDTH:0]        err_mag;
    logic                        in_window;
    logic                        bad_sample;

    assign err_ext    = {error_0_i[ERROR_WIDTH-1], error_0_i};
    assign err_mag    = err_ext[ERROR_WIDTH] ? $unsigned(-err_ext) : $unsigned(err_ext);
    assign in_window  = (err_mag <= LOCK_LIMIT);
    assign bad_sample = (err_mag > UNLOCK_LIMIT);
    assign cnt_inc    = cnt_reg + CNT_W'(1);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (force_acquire_i) begin
            state_next = ST_ACQUIRE;
            cnt_next   = '0;
        end else if (sample_valid_i) begin
            case (state_reg)
                ST_ACQUIRE: begin
                    if (in_window) begin
                        if (cnt_inc == ACQ_TARGET) begin
                            state_next = ST_TRACK;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        cnt_next = '0;
                    end
                end
                ST_TRACK: begin
                    if (bad_sample) begin
                        state_next = ST_ACQUIRE;
                        cnt_next   = '0;
                    end else if (in_window) begin
                        if (cnt_inc == TRACK_TARGET) begin
                            state_next = ST_LOCKED;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        // Between the thresholds: not bad enough to drop
                        // back, but the in-window run is broken.
                        cnt_next = '0;
                    end
                end
                ST_LOCKED: begin
                    if (bad_sample) begin
                        if (cnt_inc == UNLOCK_TARGET) begin
                            state_next = UNLOCK_DEST;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        cnt_next = '0;
                    end
                end
                default: begin
                    state_next = ST_ACQUIRE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg  <= ST_ACQUIRE;
            cnt_reg    <= '0;
            locked_reg <= 1'b0;
            update_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            locked_reg <= (state_next == ST_LOCKED);
            update_reg <= (state_next != state_reg);
        end
    end

    // Weights decode the next state so they move on the same edge as state_o.
    logic [WEIGHT_WIDTH-1:0] weight_reg [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_weight
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    weight_reg[gi] <= weight_for(ST_ACQUIRE, gi);
                end else begin
                    weight_reg[gi] <= weight_for(state_next, gi);
                end
            end
        end
    endgenerate

    assign weight_0_o       = weight_reg[0];
    assign weight_1_o       = weight_reg[1];
    assign weight_2_o       = weight_reg[2];
    assign weight_3_o       = weight_reg[3];
    assign state_o          = state_reg;
    assign locked_o         = locked_reg;
    assign weights_update_o = update_reg;

endmodule
